// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED tape arbiter.
// Holds the colour struct, the ownership state enum and the round-robin pick function
// used by led_arb_rr.
package led_arb_pkg;

   localparam int RGB_W     = 24;
   localparam int MAX_SRC   = 8;
   localparam int MAX_IDX_W = 3;

   // One LED colour; r is the most significant byte, matching the tape's {R,G,B} order.
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Tape ownership: nobody, or the source held in owner_q.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   // Result of a round-robin search.
   typedef struct packed {
      logic                 valid;
      logic [MAX_IDX_W-1:0] idx;
   } rr_pick_t;

   // Search the first n want bits, starting at ptr and wrapping once.
   // The first requester found from ptr onwards wins.
   function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0]   want,
                                        input logic [MAX_IDX_W-1:0] ptr,
                                        input int                   n);
      rr_pick_t res;
      int       c;
      res = '0;
      for (int k = 0; k < MAX_SRC; k++) begin
         if (k < n) begin
            c = int'(ptr) + k;
            if (c >= n) begin
               c = c - n;
            end
            if (!res.valid && want[3'(c)]) begin
               res.valid = 1'b1;
               res.idx   = 3'(c);
            end
         end
      end
      return res;
   endfunction

   // Darken a colour by shifting each 8-bit channel right; sh=0 leaves it unchanged.
   function automatic rgb_t rgb_dim(input rgb_t c, input logic [2:0] sh);
      rgb_t o;
      o.r = c.r >> sh;
      o.g = c.g >> sh;
      o.b = c.b >> sh;
      return o;
   endfunction

endpackage

// File: rtl/led_arb_rr.sv
// Combinational round-robin picker for the LED tape arbiter.
// Returns the first asserted want bit at or after ptr (wrapping at N_SRC).
module led_arb_rr
   import led_arb_pkg::*;
#(
   parameter int N_SRC = 2,
   parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic [N_SRC-1:0] want,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   rr_pick_t pick;

   // Zero-extend to the package's fixed width and search the live sources only.
   always_comb begin
      pick  = rr_pick(MAX_SRC'(want), MAX_IDX_W'(ptr), N_SRC);
      valid = pick.valid;
      idx   = IDX_W'(pick.idx);
   end

endmodule

// File: rtl/led_tape_arbiter.sv
// Shares one LED_tape serial driver between N_SRC pattern generators.
// Ownership moves only at frame boundaries (first latch slot of a frame), so every
// frame on the tape comes entirely from a single source.
// Build option: define LED_ARB_DIM_EN to add a dim[2:0] input that right-shifts each
// forwarded colour channel before it is registered.
//
// Tape handshake: a slot is presented when tape_req=1; that same clock the driver
// samples our RGB, which we register here so tape_rgb carries the colour for the slot
// from the following clock (one clock latency) and holds it while tape_req=0.
// tape_sync=1 marks a latch slot and always gets black. The first sync slot after a
// non-sync slot is the frame boundary; the first non-sync slot after a sync slot is
// the frame start.
module led_tape_arbiter
   import led_arb_pkg::*;
#(
   parameter int N_SRC      = 2,
   parameter int NUM_W      = 16,
   parameter int MIN_FRAMES = 4
) (
`ifdef LED_ARB_DIM_EN
   input  logic [2:0]           dim,
`endif
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tape_req,
   input  logic                 tape_sync,
   input  logic [NUM_W-1:0]     tape_num,
   output logic [RGB_W-1:0]     tape_rgb,
   input  logic [N_SRC-1:0]     src_want,
   input  logic [RGB_W*N_SRC-1:0] src_rgb,
   output logic [N_SRC-1:0]     src_grant,
   output logic [NUM_W-1:0]     src_num,
   output logic [N_SRC-1:0]     src_fstart
);

   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int CNT_W = $clog2(MIN_FRAMES + 1);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAMES);

   // Registered state
   logic             prev_sync_q, prev_sync_d;
   state_t           state_q,     state_d;
   logic [IDX_W-1:0] owner_q,     owner_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
   logic [N_SRC-1:0] grant_q,     grant_d;
   logic [N_SRC-1:0] fstart_q,    fstart_d;
   rgb_t             rgb_q,       rgb_d;

   // Combinational helpers
   logic             boundary;
   logic             frame_start;
   logic [N_SRC-1:0] owner_mask;
   logic [N_SRC-1:0] rr_want;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [CNT_W-1:0] cnt_inc;
   logic             take;
   rgb_t             owner_rgb;
   rgb_t             fwd_rgb;

   // Index that follows i in round-robin order.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      if (i == IDX_W'(N_SRC - 1)) begin
         return '0;
      end
      return i + 1'b1;
   endfunction

   // The index bus is shared by all sources without qualification.
   assign src_num = tape_num;

   // Frame boundary / frame start detection from the sync flag of the previous request.
   always_comb begin
      boundary    = tape_req && tape_sync && !prev_sync_q;
      frame_start = tape_req && !tape_sync && prev_sync_q;
      prev_sync_d = tape_req ? tape_sync : prev_sync_q;
   end

   // The current owner never competes against itself for the next grant.
   always_comb begin
      owner_mask = '0;
      if (state_q == ST_OWN) begin
         owner_mask[owner_q] = 1'b1;
      end
      rr_want = src_want & ~owner_mask;
   end

   led_arb_rr #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_rr (
      .want  (rr_want),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Ownership decisions, taken only on the frame boundary clock.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      take     = 1'b0;
      cnt_inc  = (cnt_q >= MIN_CNT) ? cnt_q : cnt_q + 1'b1;

      if (boundary) begin
         if (state_q == ST_IDLE) begin
            take = pick_valid;
         end else begin
            cnt_d = cnt_inc;
            if (!src_want[owner_q]) begin
               // Owner let go: hand over at once, or fall back to idle.
               if (pick_valid) begin
                  take = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  owner_d = '0;
                  cnt_d   = '0;
               end
            end else if (pick_valid && (cnt_inc >= MIN_CNT)) begin
               // Owner has had its minimum run and someone else is waiting.
               take = 1'b1;
            end
         end

         if (take) begin
            state_d  = ST_OWN;
            owner_d  = pick_idx;
            cnt_d    = '0;
            rr_ptr_d = next_idx(pick_idx);
         end
      end
   end

   // Select the owner's colour slice and optionally dim it.
   always_comb begin
      owner_rgb = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (owner_q == IDX_W'(i)) begin
            owner_rgb = src_rgb[i*RGB_W +: RGB_W];
         end
      end
`ifdef LED_ARB_DIM_EN
      fwd_rgb = rgb_dim(owner_rgb, dim);
`else
      fwd_rgb = owner_rgb;
`endif
   end

   // Next values of the registered outputs: grant, frame-start pulse, tape colour.
   always_comb begin
      grant_d = '0;
      if (state_d == ST_OWN) begin
         grant_d[owner_d] = 1'b1;
      end

      fstart_d = '0;
      if (frame_start && (state_q == ST_OWN)) begin
         fstart_d = grant_q;
      end

      rgb_d = rgb_q;
      if (tape_req) begin
         rgb_d = ((state_q == ST_OWN) && !tape_sync) ? fwd_rgb : '0;
      end
   end

   // All state and outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_sync_q <= 1'b0;
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         cnt_q       <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         fstart_q    <= '0;
         rgb_q       <= '0;
      end else begin
         prev_sync_q <= prev_sync_d;
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         fstart_q    <= fstart_d;
         rgb_q       <= rgb_d;
      end
   end

   assign tape_rgb   = rgb_q;
   assign src_grant  = grant_q;
   assign src_fstart = fstart_q;

endmodule
